// File: rtl/i2cmb_txn_sequencer_if.sv
// rtl/i2cmb_txn_sequencer_if.sv - request, byte-stream, result and Wishbone signals of the sequencer
interface i2cmb_txn_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [3:0] req_bus_id;
  logic [6:0] req_addr;
  logic [7:0] req_len;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic [2:0] status;
  logic       cyc_o;
  logic       stb_o;
  logic       we_o;
  logic [1:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       ack_i;
  logic       irq_i;

  modport master (
    input  req_valid, req_rw, req_bus_id, req_addr, req_len,
    input  wr_data, wr_valid, dat_i, ack_i, irq_i,
    output req_ready, wr_ready, rd_data, rd_valid, done, status,
    output cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output req_valid, req_rw, req_bus_id, req_addr, req_len,
    output wr_data, wr_valid, dat_i, ack_i, irq_i,
    input  req_ready, wr_ready, rd_data, rd_valid, done, status,
    input  cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/i2cmb_txn_sequencer.sv
// rtl/i2cmb_txn_sequencer.sv - runs one complete I2C transaction per request through the I2CMB register file
module i2cmb_txn_sequencer #(
  parameter int NUM_I2C_BUSSES = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                   clk_i,
  input logic                   rst_i,
  i2cmb_txn_sequencer_if.master bus
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_EN   = 4'd1;
  localparam logic [3:0] ST_BUS  = 4'd2;
  localparam logic [3:0] ST_CMDW = 4'd3;
  localparam logic [3:0] ST_IRQ  = 4'd4;
  localparam logic [3:0] ST_CMDR = 4'd5;
  localparam logic [3:0] ST_ADDR = 4'd6;
  localparam logic [3:0] ST_WGET = 4'd7;
  localparam logic [3:0] ST_WDPR = 4'd8;
  localparam logic [3:0] ST_RDPR = 4'd9;
  localparam logic [3:0] ST_TOFF = 4'd10;

  localparam logic [2:0] SP_BUS   = 3'd0;
  localparam logic [2:0] SP_START = 3'd1;
  localparam logic [2:0] SP_ADDR  = 3'd2;
  localparam logic [2:0] SP_WDATA = 3'd3;
  localparam logic [2:0] SP_RDATA = 3'd4;
  localparam logic [2:0] SP_STOP  = 3'd5;

  localparam logic [2:0] RS_OK       = 3'd0;
  localparam logic [2:0] RS_NAK_ADDR = 3'd1;
  localparam logic [2:0] RS_NAK_DATA = 3'd2;
  localparam logic [2:0] RS_AL       = 3'd3;
  localparam logic [2:0] RS_ERR      = 3'd4;
  localparam logic [2:0] RS_TIMEOUT  = 3'd5;

  localparam logic [2:0] CMD_WRITE    = 3'd1;
  localparam logic [2:0] CMD_READ_ACK = 3'd2;
  localparam logic [2:0] CMD_READ_NAK = 3'd3;
  localparam logic [2:0] CMD_START    = 3'd4;
  localparam logic [2:0] CMD_STOP     = 3'd5;
  localparam logic [2:0] CMD_SET_BUS  = 3'd6;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  logic [3:0]    state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic          enabled_q, enabled_d;
  logic          rw_q, rw_d;
  logic [3:0]    bus_q, bus_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    wbyte_q, wbyte_d;
  logic [2:0]    result_q, result_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [1:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          rd_valid_q, rd_valid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          done_q, done_d;
  logic [2:0]    status_q, status_d;

  logic       wb_ack;
  logic       launch;
  logic       fin;
  logic [2:0] fin_code;
  logic [2:0] fail_code;
  logic [2:0] cmd;
  logic       bus_ok;
  logic       access_state;

  assign wb_ack = cyc_q & bus.ack_i;
  assign bus_ok = int'({28'd0, bus.req_bus_id}) < NUM_I2C_BUSSES;
  assign access_state = (state_q == ST_EN)   || (state_q == ST_BUS)  || (state_q == ST_CMDW) ||
                        (state_q == ST_CMDR) || (state_q == ST_ADDR) || (state_q == ST_WDPR) ||
                        (state_q == ST_RDPR) || (state_q == ST_TOFF);

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    enabled_d  = enabled_q;
    rw_d       = rw_q;
    bus_d      = bus_q;
    addr_d     = addr_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wbyte_d    = wbyte_q;
    result_d   = result_q;
    tmr_d      = tmr_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    status_d   = status_q;
    fin        = 1'b0;
    fin_code   = RS_OK;
    fail_code  = RS_OK;
    cmd        = CMD_STOP;
    // An access state with nothing on the bus starts its access; the idle gap after an ack comes from this.
    launch     = access_state && !cyc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          rw_d     = bus.req_rw;
          bus_d    = bus.req_bus_id;
          addr_d   = bus.req_addr;
          len_d    = bus.req_len;
          cnt_d    = 8'd0;
          result_d = RS_OK;
          step_d   = SP_BUS;
          if (!bus_ok) begin
            fin      = 1'b1;
            fin_code = RS_ERR;
          end else begin
            state_d = enabled_q ? ST_BUS : ST_EN;
            launch  = 1'b1;
          end
        end
      end
      ST_EN: begin
        if (wb_ack) begin
          enabled_d = 1'b1;
          state_d   = ST_BUS;
        end
      end
      ST_BUS, ST_ADDR, ST_WDPR: begin
        if (wb_ack) state_d = ST_CMDW;
      end
      ST_CMDW: begin
        if (wb_ack) begin
          state_d = ST_IRQ;
          tmr_d   = '0;
        end
      end
      ST_IRQ: begin
        if (bus.irq_i) begin
          state_d = ST_CMDR;
          launch  = 1'b1;
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_TOFF;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_TOFF: begin
        if (wb_ack) begin
          enabled_d = 1'b0;
          fin       = 1'b1;
          fin_code  = RS_TIMEOUT;
        end
      end
      ST_WGET: begin
        if (bus.wr_valid) begin
          wbyte_d = bus.wr_data;
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_WDPR;
        end
      end
      ST_RDPR: begin
        if (wb_ack) begin
          rd_valid_d = 1'b1;
          rd_data_d  = bus.dat_i;
          cnt_d      = cnt_q + 8'd1;
          state_d    = ST_CMDW;
          if (cnt_q + 8'd1 == len_q) step_d = SP_STOP;
        end
      end
      ST_CMDR: begin
        if (wb_ack) begin
          if (bus.dat_i[5])      fail_code = RS_AL;
          else if (bus.dat_i[4]) fail_code = RS_ERR;
          else if (bus.dat_i[6]) begin
            if (step_q == SP_ADDR)                              fail_code = RS_NAK_ADDR;
            else if (step_q == SP_WDATA || step_q == SP_RDATA) fail_code = RS_NAK_DATA;
            else                                                fail_code = RS_ERR;
          end
          else if (!bus.dat_i[7]) fail_code = RS_ERR;

          // A NAK recorded before STOP outranks whatever STOP itself reports.
          if (step_q == SP_STOP) begin
            fin      = 1'b1;
            fin_code = (result_q != RS_OK) ? result_q : fail_code;
          end else if (fail_code == RS_NAK_ADDR || fail_code == RS_NAK_DATA) begin
            result_d = fail_code;
            step_d   = SP_STOP;
            state_d  = ST_CMDW;
          end else if (fail_code != RS_OK) begin
            fin      = 1'b1;
            fin_code = fail_code;
          end else begin
            case (step_q)
              SP_BUS: begin
                step_d  = SP_START;
                state_d = ST_CMDW;
              end
              SP_START: begin
                step_d  = SP_ADDR;
                state_d = ST_ADDR;
              end
              SP_ADDR: begin
                if (len_q == 8'd0) begin
                  step_d  = SP_STOP;
                  state_d = ST_CMDW;
                end else if (rw_q) begin
                  step_d  = SP_RDATA;
                  state_d = ST_CMDW;
                end else begin
                  step_d  = SP_WDATA;
                  state_d = ST_WGET;
                end
              end
              SP_WDATA: begin
                if (cnt_q == len_q) begin
                  step_d  = SP_STOP;
                  state_d = ST_CMDW;
                end else begin
                  state_d = ST_WGET;
                end
              end
              SP_RDATA: state_d = ST_RDPR;
              default: begin
                fin      = 1'b1;
                fin_code = RS_ERR;
              end
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (fin) begin
      state_d  = ST_IDLE;
      done_d   = 1'b1;
      status_d = fin_code;
    end

    case (step_d)
      SP_BUS:   cmd = CMD_SET_BUS;
      SP_START: cmd = CMD_START;
      SP_ADDR:  cmd = CMD_WRITE;
      SP_WDATA: cmd = CMD_WRITE;
      SP_RDATA: cmd = (cnt_d == len_d - 8'd1) ? CMD_READ_NAK : CMD_READ_ACK;
      default:  cmd = CMD_STOP;
    endcase

    if (launch) begin
      cyc_d = 1'b1;
      we_d  = 1'b1;
      adr_d = REG_DPR;
      dat_d = 8'h00;
      case (state_d)
        ST_EN: begin
          adr_d = REG_CSR;
          dat_d = 8'hC0;
        end
        ST_BUS:  dat_d = {4'd0, bus_d};
        ST_CMDW: begin
          adr_d = REG_CMDR;
          dat_d = {5'd0, cmd};
        end
        ST_CMDR: begin
          we_d  = 1'b0;
          adr_d = REG_CMDR;
        end
        ST_ADDR: dat_d = {addr_d, rw_d};
        ST_WDPR: dat_d = wbyte_q;
        ST_RDPR: we_d  = 1'b0;
        ST_TOFF: adr_d = REG_CSR;
        default: cyc_d = 1'b0;
      endcase
    end else if (wb_ack) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      adr_d = 2'd0;
      dat_d = 8'h00;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      step_q     <= SP_BUS;
      enabled_q  <= 1'b0;
      rw_q       <= 1'b0;
      bus_q      <= 4'd0;
      addr_q     <= 7'd0;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      wbyte_q    <= 8'd0;
      result_q   <= RS_OK;
      tmr_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= 2'd0;
      dat_q      <= 8'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'd0;
      done_q     <= 1'b0;
      status_q   <= RS_OK;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      enabled_q  <= enabled_d;
      rw_q       <= rw_d;
      bus_q      <= bus_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wbyte_q    <= wbyte_d;
      result_q   <= result_d;
      tmr_q      <= tmr_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      status_q   <= status_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.wr_ready  = (state_q == ST_WGET);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.done      = done_q;
  assign bus.status    = status_q;
  assign bus.cyc_o     = cyc_q;
  assign bus.stb_o     = cyc_q;
  assign bus.we_o      = we_q;
  assign bus.adr_o     = adr_q;
  assign bus.dat_o     = dat_q;
endmodule
